// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - round-robin arbiter sharing one dispatch/busy memory port among requesters
module mem_bus_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int MW_W    = 2,
  localparam int ID_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                        clk_in,
  input  logic                        rst_n_in,
  input  logic [NUM_REQ-1:0]          req_dispatch_read,
  input  logic [NUM_REQ-1:0]          req_dispatch_write,
  input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
  input  logic [NUM_REQ*MW_W-1:0]     req_width,
  input  logic [NUM_REQ*DATA_W-1:0]   req_wdata,
  output logic [NUM_REQ-1:0]          req_busy,
  output logic [NUM_REQ*DATA_W-1:0]   req_rdata,
  output logic                        mem_dispatch_read,
  output logic                        mem_dispatch_write,
  output logic [ADDR_W-1:0]           mem_addr,
  output logic [MW_W-1:0]             mem_width,
  output logic [DATA_W-1:0]           mem_wdata,
  input  logic                        mem_busy,
  input  logic [DATA_W-1:0]           mem_rdata,
  output logic [ID_W-1:0]             grant_id
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ISSUED = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t state;

  // One latched transaction per requester; a slot is frozen while its pending bit is set.
  logic [NUM_REQ-1:0] pending;
  logic [ADDR_W-1:0]  slot_addr  [NUM_REQ];
  logic [MW_W-1:0]    slot_width [NUM_REQ];
  logic [DATA_W-1:0]  slot_wdata [NUM_REQ];
  logic [NUM_REQ-1:0] slot_write;

  // Last granted requester; the scan for the next grant starts just after it.
  logic [ID_W-1:0]    rr_ptr;
  logic [ID_W-1:0]    next_gnt;
  logic [ID_W-1:0]    scan_idx;
  logic               gnt_found;
  logic               any_pending;
  logic               xfer_done;

  assign req_busy    = pending;
  assign any_pending = |pending;
  // Memory has dropped busy after accepting our dispatch: the granted transaction is complete.
  assign xfer_done   = (state == S_WAIT) && !mem_busy;

  // Pick the first pending slot after rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    next_gnt  = rr_ptr;
    scan_idx  = rr_ptr;
    gnt_found = 1'b0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      scan_idx = ID_W'((int'(rr_ptr) + off) % NUM_REQ);
      if (!gnt_found && pending[scan_idx]) begin
        next_gnt  = scan_idx;
        gnt_found = 1'b1;
      end
    end
  end

  // Capture new requests into idle slots and retire the granted slot on completion.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      pending    <= '0;
      slot_write <= '0;
      for (int i = 0; i < NUM_REQ; i++) begin
        slot_addr[i]  <= '0;
        slot_width[i] <= '0;
        slot_wdata[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (xfer_done && (grant_id == ID_W'(i))) begin
          pending[i] <= 1'b0;
        end else if ((req_dispatch_read[i] || req_dispatch_write[i]) && !pending[i]) begin
          // A simultaneous read+write pulse is resolved as a write.
          pending[i]    <= 1'b1;
          slot_write[i] <= req_dispatch_write[i];
          slot_addr[i]  <= req_addr[i*ADDR_W +: ADDR_W];
          slot_width[i] <= req_width[i*MW_W +: MW_W];
          slot_wdata[i] <= req_wdata[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  // Downstream sequencer: grant, one-cycle dispatch pulse, then wait for busy to fall.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state              <= S_IDLE;
      rr_ptr             <= ID_W'(NUM_REQ - 1);
      grant_id           <= '0;
      mem_dispatch_read  <= 1'b0;
      mem_dispatch_write <= 1'b0;
      mem_addr           <= '0;
      mem_width          <= '0;
      mem_wdata          <= '0;
      req_rdata          <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          mem_dispatch_read  <= 1'b0;
          mem_dispatch_write <= 1'b0;
          // A busy still high here belongs to a transaction abandoned by reset; let it drain.
          if (any_pending && !mem_busy) begin
            grant_id           <= next_gnt;
            rr_ptr             <= next_gnt;
            mem_addr           <= slot_addr[next_gnt];
            mem_width          <= slot_width[next_gnt];
            mem_wdata          <= slot_wdata[next_gnt];
            mem_dispatch_write <= slot_write[next_gnt];
            mem_dispatch_read  <= !slot_write[next_gnt];
            state              <= S_ISSUED;
          end
        end
        S_ISSUED: begin
          // Memory raises busy during this cycle, so completion is only watched from WAIT.
          mem_dispatch_read  <= 1'b0;
          mem_dispatch_write <= 1'b0;
          state              <= S_WAIT;
        end
        S_WAIT: begin
          if (!mem_busy) begin
            if (!slot_write[grant_id]) begin
              req_rdata[grant_id*DATA_W +: DATA_W] <= mem_rdata;
            end
            state <= S_IDLE;
          end
        end
        default: begin
          mem_dispatch_read  <= 1'b0;
          mem_dispatch_write <= 1'b0;
          state              <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - directed self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  localparam int NUM_REQ = 2;
  localparam int ADDR_W  = 32;
  localparam int DATA_W  = 32;
  localparam int MW_W    = 2;

  logic                      clk_in = 1'b0;
  logic                      rst_n_in;
  logic [NUM_REQ-1:0]        req_dispatch_read;
  logic [NUM_REQ-1:0]        req_dispatch_write;
  logic [NUM_REQ*ADDR_W-1:0] req_addr;
  logic [NUM_REQ*MW_W-1:0]   req_width;
  logic [NUM_REQ*DATA_W-1:0] req_wdata;
  logic [NUM_REQ-1:0]        req_busy;
  logic [NUM_REQ*DATA_W-1:0] req_rdata;
  logic                      mem_dispatch_read;
  logic                      mem_dispatch_write;
  logic [ADDR_W-1:0]         mem_addr;
  logic [MW_W-1:0]           mem_width;
  logic [DATA_W-1:0]         mem_wdata;
  logic                      mem_busy;
  logic [DATA_W-1:0]         mem_rdata;
  logic [0:0]                grant_id;

  mem_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MW_W(MW_W)
  ) dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in),
    .req_dispatch_read(req_dispatch_read), .req_dispatch_write(req_dispatch_write),
    .req_addr(req_addr), .req_width(req_width), .req_wdata(req_wdata),
    .req_busy(req_busy), .req_rdata(req_rdata),
    .mem_dispatch_read(mem_dispatch_read), .mem_dispatch_write(mem_dispatch_write),
    .mem_addr(mem_addr), .mem_width(mem_width), .mem_wdata(mem_wdata),
    .mem_busy(mem_busy), .mem_rdata(mem_rdata), .grant_id(grant_id)
  );

  always #5 clk_in = ~clk_in;

  // Memory model: busy for lat cycles starting the cycle after a dispatch.
  int   lat = 1;
  int   busy_cnt = 0;
  logic ext_busy = 1'b0;
  int   cyc = 0;
  assign mem_busy = (busy_cnt != 0) || ext_busy;

  always @(posedge clk_in) begin
    cyc <= cyc + 1;
    if (!rst_n_in) busy_cnt <= 0;
    else if (mem_dispatch_read || mem_dispatch_write) busy_cnt <= lat;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end

  typedef struct {
    int          cyc;
    logic [0:0]  gid;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        rd;
    logic        wr;
  } log_t;
  log_t log_q[$];
  log_t mon_e;

  // Record every downstream dispatch with its cycle stamp.
  always @(negedge clk_in) begin
    if (mem_dispatch_read || mem_dispatch_write) begin
      mon_e.cyc   = cyc;
      mon_e.gid   = grant_id;
      mon_e.addr  = mem_addr;
      mon_e.wdata = mem_wdata;
      mon_e.rd    = mem_dispatch_read;
      mon_e.wr    = mem_dispatch_write;
      log_q.push_back(mon_e);
    end
  end

  typedef struct {
    logic        rd;
    logic [31:0] addr;
    logic [1:0]  exp_busy;
    logic        exp_disp_rd;
    logic        exp_mem_busy;
    logic [31:0] exp_maddr;
    logic [31:0] exp_rdata0;
  } vec_t;
  vec_t vt[9];

  int passed = 0;
  int total  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(negedge clk_in);
  endtask

  task automatic clear_in();
    req_dispatch_read  = '0;
    req_dispatch_write = '0;
    req_addr           = '0;
    req_width          = '0;
    req_wdata          = '0;
  endtask

  task automatic set_req(input int i, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    req_dispatch_read[i]      = r;
    req_dispatch_write[i]     = w;
    req_addr[i*ADDR_W +: ADDR_W] = a;
    req_wdata[i*DATA_W +: DATA_W] = d;
    req_width[i*MW_W +: MW_W] = 2'd2;
  endtask

  task automatic do_reset();
    tick();
    rst_n_in = 1'b0;
    ext_busy = 1'b0;
    clear_in();
    tick();
    tick();
    rst_n_in = 1'b1;
    tick();
    log_q.delete();
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while ((req_busy != 0 || mem_busy) && n < 200) begin
      tick();
      n++;
    end
    check({name, "_idle_reached"}, (n < 200), 1);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   t0;
    int   n0;
    int   r;
    logic b1_ok;

    vt[0] = '{1'b1, 32'h100, 2'b00, 1'b0, 1'b0, 32'h0,   32'h0};
    vt[1] = '{1'b0, 32'h0,   2'b01, 1'b0, 1'b0, 32'h0,   32'h0};
    vt[2] = '{1'b0, 32'h0,   2'b01, 1'b1, 1'b0, 32'h100, 32'h0};
    vt[3] = '{1'b0, 32'h0,   2'b01, 1'b0, 1'b1, 32'h100, 32'h0};
    vt[4] = '{1'b0, 32'h0,   2'b01, 1'b0, 1'b1, 32'h100, 32'h0};
    vt[5] = '{1'b0, 32'h0,   2'b01, 1'b0, 1'b1, 32'h100, 32'h0};
    vt[6] = '{1'b0, 32'h0,   2'b01, 1'b0, 1'b1, 32'h100, 32'h0};
    vt[7] = '{1'b0, 32'h0,   2'b01, 1'b0, 1'b0, 32'h100, 32'h0};
    vt[8] = '{1'b0, 32'h0,   2'b00, 1'b0, 1'b0, 32'h100, 32'hDEADBEEF};

    rst_n_in  = 1'b0;
    mem_rdata = '0;
    clear_in();
    do_reset();

    // Reset state
    check("rst_req_busy", req_busy, 0);
    check("rst_disp", {mem_dispatch_read, mem_dispatch_write}, 0);
    check("rst_grant", grant_id, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_rdata", req_rdata, 0);

    // Single read, table driven cycle by cycle
    lat       = 4;
    mem_rdata = 32'hDEADBEEF;
    for (int c = 0; c < 9; c++) begin
      check($sformatf("t1_c%0d_busy", c), req_busy, vt[c].exp_busy);
      check($sformatf("t1_c%0d_disp_rd", c), mem_dispatch_read, vt[c].exp_disp_rd);
      check($sformatf("t1_c%0d_disp_wr", c), mem_dispatch_write, 0);
      check($sformatf("t1_c%0d_mem_busy", c), mem_busy, vt[c].exp_mem_busy);
      check($sformatf("t1_c%0d_mem_addr", c), mem_addr, vt[c].exp_maddr);
      check($sformatf("t1_c%0d_rdata0", c), req_rdata[31:0], vt[c].exp_rdata0);
      clear_in();
      if (vt[c].rd) set_req(0, 1'b1, 1'b0, vt[c].addr, 32'h0);
      tick();
    end
    check("t1_mem_width", mem_width, 2);

    // Simultaneous read on req0 and write on req1
    do_reset();
    lat       = 2;
    mem_rdata = 32'hA5;
    t0 = cyc;
    set_req(0, 1'b1, 1'b0, 32'h10, 32'h0);
    set_req(1, 1'b0, 1'b1, 32'h20, 32'h55);
    tick();
    clear_in();
    b1_ok = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      if (req_busy[1] !== 1'b1) b1_ok = 1'b0;
      tick();
    end
    check("t2_busy1_held", b1_ok, 1);
    check("t2_busy1_fall", req_busy[1], 0);
    check("t2_rdata0", req_rdata[31:0], 32'hA5);
    check("t2_log_size", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t2_first_gid", log_q[0].gid, 0);
      check("t2_first_cyc", log_q[0].cyc, t0 + 2);
      check("t2_first_rd", {log_q[0].rd, log_q[0].wr}, 2'b10);
      check("t2_first_addr", log_q[0].addr, 32'h10);
      check("t2_second_gid", log_q[1].gid, 1);
      check("t2_second_cyc", log_q[1].cyc, t0 + 7);
      check("t2_second_wr", {log_q[1].rd, log_q[1].wr}, 2'b01);
      check("t2_second_addr", log_q[1].addr, 32'h20);
      check("t2_second_wdata", log_q[1].wdata, 32'h55);
    end

    // Fairness: req0 hammers, req1 issues once
    do_reset();
    lat = 1;
    n0  = 0;
    for (int k = 0; k < 40; k++) begin
      clear_in();
      if (k == 0) set_req(1, 1'b1, 1'b0, 32'hB0, 32'h0);
      if (req_busy[0] == 1'b0 && n0 < 3) begin
        set_req(0, 1'b1, 1'b0, 32'hA0 + n0, 32'h0);
        n0++;
      end
      tick();
    end
    clear_in();
    wait_idle("t3");
    check("t3_log_size", log_q.size(), 4);
    if (log_q.size() == 4) begin
      check("t3_gnt_order", {log_q[0].gid, log_q[1].gid, log_q[2].gid, log_q[3].gid}, 4'b0100);
      check("t3_addr0", log_q[0].addr, 32'hA0);
      check("t3_addr1", log_q[1].addr, 32'hB0);
      check("t3_addr2", log_q[2].addr, 32'hA1);
      check("t3_addr3", log_q[3].addr, 32'hA2);
    end

    // Pulses while busy are ignored; read+write together is a write
    do_reset();
    lat = 3;
    set_req(0, 1'b1, 1'b0, 32'h300, 32'h0);
    tick();
    clear_in();
    set_req(0, 1'b0, 1'b1, 32'h301, 32'h9);
    tick();
    clear_in();
    tick();
    set_req(0, 1'b1, 1'b0, 32'h302, 32'h0);
    tick();
    clear_in();
    wait_idle("t4a");
    check("t4_single_dispatch", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("t4_first_addr", log_q[0].addr, 32'h300);
      check("t4_first_rw", {log_q[0].rd, log_q[0].wr}, 2'b10);
    end
    set_req(0, 1'b1, 1'b1, 32'h400, 32'h77);
    tick();
    clear_in();
    wait_idle("t4b");
    check("t4_rw_log_size", log_q.size(), 2);
    if (log_q.size() == 2) begin
      check("t4_rw_is_write", {log_q[1].rd, log_q[1].wr}, 2'b01);
      check("t4_rw_addr", log_q[1].addr, 32'h400);
      check("t4_rw_wdata", log_q[1].wdata, 32'h77);
    end

    // Reset mid-WAIT with memory still busy
    do_reset();
    lat = 10;
    set_req(0, 1'b1, 1'b0, 32'h321, 32'h0);
    tick();
    clear_in();
    tick();
    tick();
    tick();
    check("t5_pre_busy", req_busy, 2'b01);
    check("t5_pre_mem_busy", mem_busy, 1);
    rst_n_in = 1'b0;
    ext_busy = 1'b1;
    #1;
    check("t5_rst_busy", req_busy, 0);
    check("t5_rst_disp", {mem_dispatch_read, mem_dispatch_write}, 0);
    check("t5_rst_addr", mem_addr, 0);
    check("t5_rst_grant", grant_id, 0);
    tick();
    rst_n_in = 1'b1;
    log_q.delete();
    r = cyc;
    set_req(1, 1'b1, 1'b0, 32'h500, 32'h0);
    tick();
    clear_in();
    tick();
    tick();
    ext_busy = 1'b0;
    wait_idle("t5");
    check("t5_log_size", log_q.size(), 1);
    if (log_q.size() == 1) begin
      check("t5_disp_cyc", log_q[0].cyc, r + 4);
      check("t5_disp_gid", log_q[0].gid, 1);
      check("t5_disp_addr", log_q[0].addr, 32'h500);
    end

    // Read data isolation between requesters
    do_reset();
    lat       = 2;
    mem_rdata = 32'h1;
    set_req(0, 1'b1, 1'b0, 32'h600, 32'h0);
    tick();
    clear_in();
    wait_idle("t6a");
    check("t6_rdata0_first", req_rdata[31:0], 32'h1);
    mem_rdata = 32'h2;
    set_req(1, 1'b1, 1'b0, 32'h700, 32'h0);
    tick();
    clear_in();
    wait_idle("t6b");
    check("t6_rdata1", req_rdata[63:32], 32'h2);
    check("t6_rdata0_kept", req_rdata[31:0], 32'h1);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
